// File: rtl/csel_subtractor_pipe.sv
// Two-stage pipelined 16-bit carry-select subtractor: diff = a + ~b + 1.
// Groups [1:0] [3:2] [6:4] [10:7] [15:11]. The upper groups keep a
// carry-in-0 ripple sum and a BEC-incremented carry-in-1 copy. Stage 2
// picks between them along the group carry chain.
module csel_subtractor_pipe #(
    parameter int WIDTH    = 16,
    parameter bit FLAGS_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             ovf,
    output logic             lt_s
);

    // The group partition is hard-wired to 16 bits.
    if (WIDTH != 16) begin : g_badWidth
        $error("csel_subtractor_pipe: WIDTH must be 16");
    end

    logic        w_adv1, w_adv2, w_inFire;
    logic [15:0] w_nb;

    logic [1:0]  w_sumG0;
    logic        w_c0;
    logic [1:0]  w_sum0G1, w_sum1G1;
    logic [2:0]  w_sum0G2, w_sum1G2;
    logic [3:0]  w_sum0G3, w_sum1G3;
    logic [4:0]  w_sum0G4, w_sum1G4;
    logic        w_cout0G1, w_cout0G2, w_cout0G3, w_cout0G4;
    logic        w_cout1G1, w_cout1G2, w_cout1G3, w_cout1G4;

    logic        r_s1Valid;
    logic [1:0]  r_sumG0;
    logic        r_c0;
    logic [1:0]  r_sum0G1, r_sum1G1;
    logic [2:0]  r_sum0G2, r_sum1G2;
    logic [3:0]  r_sum0G3, r_sum1G3;
    logic [4:0]  r_sum0G4, r_sum1G4;
    logic        r_cout0G1, r_cout0G2, r_cout0G3, r_cout0G4;
    logic        r_cout1G1, r_cout1G2, r_cout1G3, r_cout1G4;
    logic        r_aSign, r_bSign;

    logic        w_c1, w_c2, w_c3, w_c4;
    logic [1:0]  w_dG1;
    logic [2:0]  w_dG2;
    logic [3:0]  w_dG3;
    logic [4:0]  w_dG4;
    logic [15:0] w_diff;

    logic        r_outValid;
    logic [15:0] r_diff;
    logic        r_borrow;

    // Handshake: a stage advances when the stage after it is empty or draining.
    assign w_adv2   = ~r_outValid | out_ready;
    assign w_adv1   = ~r_s1Valid | w_adv2;
    assign in_ready = w_adv1 & rst_n;
    assign w_inFire = in_valid & in_ready;

    // Stage 1 group sums: group 0 absorbs the +1, the rest get sum0 and BEC sum1.
    assign w_nb = ~b[15:0];
    assign {w_c0, w_sumG0}       = {1'b0, a[1:0]}   + {1'b0, w_nb[1:0]} + 3'd1;
    assign {w_cout0G1, w_sum0G1} = {1'b0, a[3:2]}   + {1'b0, w_nb[3:2]};
    assign {w_cout0G2, w_sum0G2} = {1'b0, a[6:4]}   + {1'b0, w_nb[6:4]};
    assign {w_cout0G3, w_sum0G3} = {1'b0, a[10:7]}  + {1'b0, w_nb[10:7]};
    assign {w_cout0G4, w_sum0G4} = {1'b0, a[15:11]} + {1'b0, w_nb[15:11]};

    assign w_sum1G1  = w_sum0G1 + 2'd1;
    assign w_sum1G2  = w_sum0G2 + 3'd1;
    assign w_sum1G3  = w_sum0G3 + 4'd1;
    assign w_sum1G4  = w_sum0G4 + 5'd1;
    assign w_cout1G1 = w_cout0G1 ^ (&w_sum0G1);
    assign w_cout1G2 = w_cout0G2 ^ (&w_sum0G2);
    assign w_cout1G3 = w_cout0G3 ^ (&w_sum0G3);
    assign w_cout1G4 = w_cout0G4 ^ (&w_sum0G4);

    // Stage 1 registers: capture group results on input transfer, hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1Valid <= 1'b0;
            r_sumG0   <= '0;
            r_c0      <= 1'b0;
            r_sum0G1  <= '0;
            r_sum1G1  <= '0;
            r_sum0G2  <= '0;
            r_sum1G2  <= '0;
            r_sum0G3  <= '0;
            r_sum1G3  <= '0;
            r_sum0G4  <= '0;
            r_sum1G4  <= '0;
            r_cout0G1 <= 1'b0;
            r_cout1G1 <= 1'b0;
            r_cout0G2 <= 1'b0;
            r_cout1G2 <= 1'b0;
            r_cout0G3 <= 1'b0;
            r_cout1G3 <= 1'b0;
            r_cout0G4 <= 1'b0;
            r_cout1G4 <= 1'b0;
            r_aSign   <= 1'b0;
            r_bSign   <= 1'b0;
        end else if (w_adv1) begin
            r_s1Valid <= w_inFire;
            if (w_inFire) begin
                r_sumG0   <= w_sumG0;
                r_c0      <= w_c0;
                r_sum0G1  <= w_sum0G1;
                r_sum1G1  <= w_sum1G1;
                r_sum0G2  <= w_sum0G2;
                r_sum1G2  <= w_sum1G2;
                r_sum0G3  <= w_sum0G3;
                r_sum1G3  <= w_sum1G3;
                r_sum0G4  <= w_sum0G4;
                r_sum1G4  <= w_sum1G4;
                r_cout0G1 <= w_cout0G1;
                r_cout1G1 <= w_cout1G1;
                r_cout0G2 <= w_cout0G2;
                r_cout1G2 <= w_cout1G2;
                r_cout0G3 <= w_cout0G3;
                r_cout1G3 <= w_cout1G3;
                r_cout0G4 <= w_cout0G4;
                r_cout1G4 <= w_cout1G4;
                r_aSign   <= a[15];
                r_bSign   <= b[15];
            end
        end
    end

    // Stage 2 select chain: each group's carry picks the next group's sum and carry.
    assign w_c1   = r_c0 ? r_cout1G1 : r_cout0G1;
    assign w_c2   = w_c1 ? r_cout1G2 : r_cout0G2;
    assign w_c3   = w_c2 ? r_cout1G3 : r_cout0G3;
    assign w_c4   = w_c3 ? r_cout1G4 : r_cout0G4;
    assign w_dG1  = r_c0 ? r_sum1G1 : r_sum0G1;
    assign w_dG2  = w_c1 ? r_sum1G2 : r_sum0G2;
    assign w_dG3  = w_c2 ? r_sum1G3 : r_sum0G3;
    assign w_dG4  = w_c3 ? r_sum1G4 : r_sum0G4;
    assign w_diff = {w_dG4, w_dG3, w_dG2, w_dG1, r_sumG0};

    // Output register: loads the selected result whenever stage 2 advances.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_diff     <= '0;
            r_borrow   <= 1'b0;
        end else if (w_adv2) begin
            r_outValid <= r_s1Valid;
            if (r_s1Valid) begin
                r_diff   <= w_diff;
                r_borrow <= ~w_c4;
            end
        end
    end

    assign out_valid = r_outValid;
    assign diff      = r_diff;
    assign borrow    = r_borrow;

    if (FLAGS_EN) begin : g_flags
        logic r_zero, r_ovf, r_ltS;
        logic w_ovf;

        assign w_ovf = (r_aSign != r_bSign) && (w_diff[15] != r_aSign);

        // Comparison flags registered alongside diff from the final result and sign bits.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_zero <= 1'b0;
                r_ovf  <= 1'b0;
                r_ltS  <= 1'b0;
            end else if (w_adv2 && r_s1Valid) begin
                r_zero <= (w_diff == 16'h0000);
                r_ovf  <= w_ovf;
                r_ltS  <= w_diff[15] ^ w_ovf;
            end
        end

        assign zero = r_zero;
        assign ovf  = r_ovf;
        assign lt_s = r_ltS;
    end else begin : g_noFlags
        assign zero = 1'b0;
        assign ovf  = 1'b0;
        assign lt_s = 1'b0;
    end

endmodule

// File: doc/csel_subtractor_pipe.md
Name: csel_subtractor_pipe

Overview:
- 16-bit, 2-stage pipelined carry-select subtractor computing diff = a - b as a + ~b + 1.
- Uses the team's square-root carry-select partition: groups [1:0], [3:2], [6:4], [10:7], [15:11]. Each upper group holds a ripple sum for carry-in 0 and a binary-to-excess-1 (BEC) incremented copy for carry-in 1.
- Valid/ready streaming handshake on both sides, with full throughput and backpressure.
- Produces borrow and comparison flags for the datapath and ALU paths that currently use the combinational adder.

Parameters:
- WIDTH, 16, operand width. Fixed at 16 because the group partition is hard-wired; any other value is a configuration error.
- FLAGS_EN, 1, when 0, the zero/ovf/lt_s outputs are tied to 0 and their logic is removed.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands this cycle.
- a  in  16  minuend, unsigned or two's complement.
- b  in  16  subtrahend.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- diff  out  16  a - b, modulo 2^16.
- borrow  out  1  1 when a < b unsigned; equals ~carry-out.
- zero  out  1  diff == 0.
- ovf  out  1  signed overflow: a[15] != b[15] and diff[15] != a[15].
- lt_s  out  1  a < b signed; equals diff[15] ^ ovf.

Behaviour:
- Reset: sampled on a clk edge with rst_n=0.
  - Clears s1_valid and out_valid.
  - Zeroes diff, borrow, zero, ovf, lt_s and all stage-1 data registers.
  - in_ready is 0 while rst_n=0 and 1 in the first cycle after release.
  - Reset mid-operation discards all in-flight results; no out_valid pulse follows.
- Handshake:
  - Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
  - adv2 = ~out_valid | out_ready.
  - adv1 = ~s1_valid | adv2.
  - in_ready = adv1 & rst_n (combinational from out_ready; no combinational path from in_valid).
  - diff and flags are stable while out_valid=1 and out_ready=0.
  - a and b may change freely when no transfer occurs.
- Stage 1 (registered on input transfer):
  - nb = ~b.
  - Group 0 ([1:0]): 2-bit ripple of a + nb with carry-in 1. Register sum and carry c_g0.
  - Groups 1-4: ripple of a + nb with carry-in 0, giving sum0 and cout0.
  - Each of groups 1-4 also gets its BEC copy: sum1 = sum0 + 1 and cout1 = cout0 ^ (&sum0). These are registered alongside sum0 and cout0.
  - Stage-1 registers hold when ~adv1. s1_valid loads in_valid & in_ready whenever adv1.
- Stage 2 (registered when adv2 & s1_valid):
  - Carry chain: c_g1 = c_g0 ? cout1_g1 : cout0_g1, and so on through g4. Each group sum is muxed by the previous group's carry.
  - diff is the concatenated result.
  - borrow = ~c_g4.
  - zero, ovf and lt_s are computed from the final diff and the stage-1 sign bits (a[15], b[15] carried forward).
  - out_valid loads s1_valid when adv2.
- Latency and throughput:
  - Exactly 2 cycles from input transfer to out_valid, given out_ready held high.
  - 1 result per cycle sustained.
  - Pipeline holds at most 2 entries; with out_ready=0, in_ready drops once both stages are full.
- Simultaneous output transfer and stage-1 advance in the same cycle: the output register is overwritten with the next result, with no bubble.
- No wrap detection beyond borrow/ovf; the modulo-2^16 result is always produced.

Test Plan:
- Basic: a=0x0005, b=0x0003, out_ready=1 -> 2 cycles later diff=0x0002, borrow=0, zero=0, ovf=0, lt_s=0.
- Borrow through all groups:
  - a=0x8000, b=0x0001 -> diff=0x7FFF, borrow=0, ovf=1, lt_s=1.
  - a=0x0000, b=0x0001 -> diff=0xFFFF, borrow=1, ovf=0, lt_s=1.
- Equality and underflow: a=b=0x1234 -> diff=0x0000, zero=1, borrow=0. Then a=0x0003, b=0x0005 -> diff=0xFFFE, borrow=1, lt_s=1.
- Streaming and backpressure:
  - Send 0x0010-0x0001, 0x0020-0x0002, 0x0030-0x0003 back-to-back, with out_ready=0 from cycle 2 for 3 cycles.
  - Required: in_ready falls after 2 accepted; diff holds 0x000F until released.
  - Then 0x000F, 0x001E, 0x002D emerge in order with no loss or duplication.
- Reset mid-flight: accept 2 operations, assert rst_n=0 for 1 cycle -> out_valid=0 and diff=0x0000 after the edge, no stale result afterwards, in_ready=1 the next cycle.
- Random: 10k random a/b with random in_valid/out_ready -> every diff/borrow/ovf matches the reference model (a - b mod 2^16, a<b unsigned/signed) in order.
